// File: rtl/lenet_load_ctrl_if.sv
// Register-file / inference-core side signals of the LeNet load sequencer.
// The master modport is the register file plus core; the slave modport is the sequencer.
interface lenet_load_ctrl_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned WADDR_W = 12,
    parameter int unsigned BADDR_W = 4,
    parameter int unsigned FADDR_W = 10,
    parameter int unsigned RES_W   = 4
);
    // Register-file controls and write stream
    logic               soft_rst;
    logic               run_en;
    logic [DATA_W-1:0]  wr_data;
    logic               weight_vld;
    logic               bias_vld;
    logic               fmap_vld;

    // Buffer write port
    logic [DATA_W-1:0]  mem_wdata;
    logic               weight_we;
    logic [WADDR_W-1:0] weight_addr;
    logic               bias_we;
    logic [BADDR_W-1:0] bias_addr;
    logic               fmap_we;
    logic [FADDR_W-1:0] fmap_addr;

    // Core handshake
    logic               core_start;
    logic               core_abort;
    logic               core_done;
    logic [RES_W-1:0]   core_result;

    // Status
    logic               done_flag;
    logic [RES_W-1:0]   result;
    logic               err_flag;
    logic [1:0]         state;

    modport master (
        output soft_rst, run_en, wr_data, weight_vld, bias_vld, fmap_vld,
        output core_done, core_result,
        input  mem_wdata, weight_we, weight_addr, bias_we, bias_addr, fmap_we, fmap_addr,
        input  core_start, core_abort, done_flag, result, err_flag, state
    );

    modport slave (
        input  soft_rst, run_en, wr_data, weight_vld, bias_vld, fmap_vld,
        input  core_done, core_result,
        output mem_wdata, weight_we, weight_addr, bias_we, bias_addr, fmap_we, fmap_addr,
        output core_start, core_abort, done_flag, result, err_flag, state
    );
endinterface

// File: rtl/lenet_load_ctrl.sv
// Load sequencer for the LeNet core: steers streamed register writes into the weight,
// bias and feature-map buffers, starts the core once all are full, and captures the result.
module lenet_load_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_WEIGHT = 3220,
    parameter int unsigned N_BIAS   = 10,
    parameter int unsigned N_FMAP   = 784,
    parameter int unsigned WADDR_W  = 12,
    parameter int unsigned BADDR_W  = 4,
    parameter int unsigned FADDR_W  = 10,
    parameter int unsigned RES_W    = 4
) (
    input logic              s00_axi_aclk,
    input logic              s00_axi_aresetn,
    lenet_load_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    // Counters are one bit wider than the address so they can hold N_* itself
    localparam logic [WADDR_W:0] WeightLimit = (WADDR_W + 1)'(N_WEIGHT);
    localparam logic [BADDR_W:0] BiasLimit   = (BADDR_W + 1)'(N_BIAS);
    localparam logic [FADDR_W:0] FmapLimit   = (FADDR_W + 1)'(N_FMAP);
    localparam logic [WADDR_W:0] WeightOne   = (WADDR_W + 1)'(1);
    localparam logic [BADDR_W:0] BiasOne     = (BADDR_W + 1)'(1);
    localparam logic [FADDR_W:0] FmapOne     = (FADDR_W + 1)'(1);

    state_e             state_q, state_d;
    logic [WADDR_W:0]   w_cnt_q, w_cnt_d;
    logic [BADDR_W:0]   b_cnt_q, b_cnt_d;
    logic [FADDR_W:0]   f_cnt_q, f_cnt_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               weight_we_q, weight_we_d;
    logic [WADDR_W-1:0] weight_addr_q, weight_addr_d;
    logic               bias_we_q, bias_we_d;
    logic [BADDR_W-1:0] bias_addr_q, bias_addr_d;
    logic               fmap_we_q, fmap_we_d;
    logic [FADDR_W-1:0] fmap_addr_q, fmap_addr_d;
    logic               start_q, start_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q, err_d;

    logic w_full, b_full, f_full, any_vld, multi_vld;

    assign w_full    = (w_cnt_q == WeightLimit);
    assign b_full    = (b_cnt_q == BiasLimit);
    assign f_full    = (f_cnt_q == FmapLimit);
    assign any_vld   = bus.weight_vld | bus.bias_vld | bus.fmap_vld;
    assign multi_vld = (bus.weight_vld & bus.bias_vld) | (bus.weight_vld & bus.fmap_vld) |
                       (bus.bias_vld & bus.fmap_vld);

    // Next-state, buffer steering and status update; soft reset overrides everything
    always_comb begin
        state_d       = state_q;
        w_cnt_d       = w_cnt_q;
        b_cnt_d       = b_cnt_q;
        f_cnt_d       = f_cnt_q;
        mem_wdata_d   = mem_wdata_q;
        weight_we_d   = 1'b0;
        weight_addr_d = weight_addr_q;
        bias_we_d     = 1'b0;
        bias_addr_d   = bias_addr_q;
        fmap_we_d     = 1'b0;
        fmap_addr_d   = fmap_addr_q;
        start_d       = 1'b0;
        abort_d       = 1'b0;
        done_d        = done_q;
        result_d      = result_q;
        err_d         = err_q;

        case (state_q)
            StIdle: begin
                w_cnt_d = '0;
                b_cnt_d = '0;
                f_cnt_d = '0;
                if (bus.run_en) state_d = StLoad;
            end
            StLoad: begin
                if (!bus.run_en) begin
                    state_d = StIdle;
                    w_cnt_d = '0;
                    b_cnt_d = '0;
                    f_cnt_d = '0;
                end else begin
                    // Only the highest-priority strobe is written; the rest are errors
                    if (multi_vld) err_d = 1'b1;
                    if (bus.weight_vld) begin
                        if (w_full) begin
                            err_d = 1'b1;
                        end else begin
                            weight_we_d   = 1'b1;
                            weight_addr_d = w_cnt_q[WADDR_W-1:0];
                            w_cnt_d       = w_cnt_q + WeightOne;
                            mem_wdata_d   = bus.wr_data;
                        end
                    end else if (bus.bias_vld) begin
                        if (b_full) begin
                            err_d = 1'b1;
                        end else begin
                            bias_we_d   = 1'b1;
                            bias_addr_d = b_cnt_q[BADDR_W-1:0];
                            b_cnt_d     = b_cnt_q + BiasOne;
                            mem_wdata_d = bus.wr_data;
                        end
                    end else if (bus.fmap_vld) begin
                        if (f_full) begin
                            err_d = 1'b1;
                        end else begin
                            fmap_we_d   = 1'b1;
                            fmap_addr_d = f_cnt_q[FADDR_W-1:0];
                            f_cnt_d     = f_cnt_q + FmapOne;
                            mem_wdata_d = bus.wr_data;
                        end
                    end
                    // Counters became full on the final write's edge, so start lands a cycle later
                    if (w_full && b_full && f_full) begin
                        start_d = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (any_vld) err_d = 1'b1;
                if (!bus.run_en) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                    w_cnt_d = '0;
                    b_cnt_d = '0;
                    f_cnt_d = '0;
                end else if (bus.core_done) begin
                    result_d = bus.core_result;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (!bus.run_en) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                    w_cnt_d = '0;
                    b_cnt_d = '0;
                    f_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.soft_rst) begin
            state_d       = StIdle;
            w_cnt_d       = '0;
            b_cnt_d       = '0;
            f_cnt_d       = '0;
            mem_wdata_d   = '0;
            weight_we_d   = 1'b0;
            weight_addr_d = '0;
            bias_we_d     = 1'b0;
            bias_addr_d   = '0;
            fmap_we_d     = 1'b0;
            fmap_addr_d   = '0;
            start_d       = 1'b0;
            abort_d       = 1'b0;
            done_d        = 1'b0;
            result_d      = '0;
            err_d         = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q       <= StIdle;
            w_cnt_q       <= '0;
            b_cnt_q       <= '0;
            f_cnt_q       <= '0;
            mem_wdata_q   <= '0;
            weight_we_q   <= 1'b0;
            weight_addr_q <= '0;
            bias_we_q     <= 1'b0;
            bias_addr_q   <= '0;
            fmap_we_q     <= 1'b0;
            fmap_addr_q   <= '0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_cnt_q       <= w_cnt_d;
            b_cnt_q       <= b_cnt_d;
            f_cnt_q       <= f_cnt_d;
            mem_wdata_q   <= mem_wdata_d;
            weight_we_q   <= weight_we_d;
            weight_addr_q <= weight_addr_d;
            bias_we_q     <= bias_we_d;
            bias_addr_q   <= bias_addr_d;
            fmap_we_q     <= fmap_we_d;
            fmap_addr_q   <= fmap_addr_d;
            start_q       <= start_d;
            abort_q       <= abort_d;
            done_q        <= done_d;
            result_q      <= result_d;
            err_q         <= err_d;
        end
    end

    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.weight_we   = weight_we_q;
    assign bus.weight_addr = weight_addr_q;
    assign bus.bias_we     = bias_we_q;
    assign bus.bias_addr   = bias_addr_q;
    assign bus.fmap_we     = fmap_we_q;
    assign bus.fmap_addr   = fmap_addr_q;
    assign bus.core_start  = start_q;
    assign bus.core_abort  = abort_q;
    assign bus.done_flag   = done_q;
    assign bus.result      = result_q;
    assign bus.err_flag    = err_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_lenet_load_ctrl.sv
// Directed + randomized bench for lenet_load_ctrl against a cycle-level behavioural model.
module tb_lenet_load_ctrl;

    localparam int N_WEIGHT = 3220;
    localparam int N_BIAS   = 10;
    localparam int N_FMAP   = 784;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        srst  = 1'b0;
    logic        run   = 1'b0;
    logic [31:0] wd    = '0;
    logic        w_v   = 1'b0;
    logic        b_v   = 1'b0;
    logic        f_v   = 1'b0;
    logic        cdone = 1'b0;
    logic [3:0]  cres  = '0;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;
    int n_abort = 0;

    // Behavioural model: phase 0..3 = idle/load/run/done, per-type fill counts
    int          m_st = 0;
    int          m_cnt[3];
    int          m_lim[3];
    bit          m_we[3];
    int          m_addr[3];
    logic [31:0] m_wdata = '0;
    bit          m_start = 0;
    bit          m_abort = 0;
    bit          m_done  = 0;
    int          m_res   = 0;
    bit          m_err   = 0;

    lenet_load_ctrl_if bus ();

    assign bus.soft_rst    = srst;
    assign bus.run_en      = run;
    assign bus.wr_data     = wd;
    assign bus.weight_vld  = w_v;
    assign bus.bias_vld    = b_v;
    assign bus.fmap_vld    = f_v;
    assign bus.core_done   = cdone;
    assign bus.core_result = cres;

    lenet_load_ctrl dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rstn),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_wdata = '0; m_start = 0; m_abort = 0; m_done = 0; m_res = 0; m_err = 0;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_we[i] = 0; m_addr[i] = 0;
        end
    endfunction

    function automatic void model_step();
        bit vld[3];
        int pick;
        bit all_full;
        vld[0] = w_v; vld[1] = b_v; vld[2] = f_v;
        for (int i = 0; i < 3; i++) m_we[i] = 0;
        m_start = 0;
        m_abort = 0;
        if (srst) begin
            model_reset();
            return;
        end
        all_full = (m_cnt[0] == m_lim[0]) && (m_cnt[1] == m_lim[1]) && (m_cnt[2] == m_lim[2]);
        case (m_st)
            0: begin
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                if (run) m_st = 1;
            end
            1: begin
                if (!run) begin
                    m_st = 0;
                    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                end else begin
                    if (int'(vld[0]) + int'(vld[1]) + int'(vld[2]) > 1) m_err = 1;
                    pick = vld[0] ? 0 : vld[1] ? 1 : vld[2] ? 2 : -1;
                    if (pick >= 0) begin
                        if (m_cnt[pick] == m_lim[pick]) m_err = 1;
                        else begin
                            m_we[pick]   = 1;
                            m_addr[pick] = m_cnt[pick];
                            m_cnt[pick]++;
                            m_wdata      = wd;
                        end
                    end
                    if (all_full) begin
                        m_start = 1;
                        m_st    = 2;
                    end
                end
            end
            2: begin
                if (vld[0] || vld[1] || vld[2]) m_err = 1;
                if (!run) begin
                    m_abort = 1;
                    m_st    = 0;
                    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                end else if (cdone) begin
                    m_res  = int'(cres);
                    m_done = 1;
                    m_st   = 3;
                end
            end
            default: begin
                if (!run) begin
                    m_st   = 0;
                    m_done = 0;
                    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        chk("state",       32'(bus.state),       32'(m_st));
        chk("weight_we",   32'(bus.weight_we),   32'(m_we[0]));
        chk("weight_addr", 32'(bus.weight_addr), 32'(m_addr[0]));
        chk("bias_we",     32'(bus.bias_we),     32'(m_we[1]));
        chk("bias_addr",   32'(bus.bias_addr),   32'(m_addr[1]));
        chk("fmap_we",     32'(bus.fmap_we),     32'(m_we[2]));
        chk("fmap_addr",   32'(bus.fmap_addr),   32'(m_addr[2]));
        chk("mem_wdata",   bus.mem_wdata,        m_wdata);
        chk("core_start",  32'(bus.core_start),  32'(m_start));
        chk("core_abort",  32'(bus.core_abort),  32'(m_abort));
        chk("done_flag",   32'(bus.done_flag),   32'(m_done));
        chk("result",      32'(bus.result),      32'(m_res));
        chk("err_flag",    32'(bus.err_flag),    32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (bus.core_start === 1'b1) n_start++;
        if (bus.core_abort === 1'b1) n_abort++;
        w_v = 0; b_v = 0; f_v = 0; cdone = 0;
    endtask

    function automatic logic [31:0] addr_of(input int k);
        case (k)
            0:       return 32'(bus.weight_addr);
            1:       return 32'(bus.bias_addr);
            default: return 32'(bus.fmap_addr);
        endcase
    endfunction

    task automatic strobe(input int k, input logic [31:0] d);
        wd = d;
        case (k)
            0:       w_v = 1;
            1:       b_v = 1;
            default: f_v = 1;
        endcase
        tick();
    endtask

    // Random interleaving of every remaining word of one image, with idle gaps
    task automatic fill(input int img, input bit idx_data);
        int rem[3];
        int idx[3];
        int r, k, tot;
        rem[0] = N_WEIGHT; rem[1] = N_BIAS; rem[2] = N_FMAP;
        idx[0] = 0; idx[1] = 0; idx[2] = 0;
        tot = rem[0] + rem[1] + rem[2];
        while (tot > 0) begin
            if ($urandom_range(0, 7) == 0) begin
                tick();
            end else begin
                r = int'($urandom_range(0, tot - 1));
                k = (r < rem[0]) ? 0 : (r < rem[0] + rem[1]) ? 1 : 2;
                strobe(k, idx_data ? 32'(idx[k] + 1000 * img) : $urandom());
                if (idx[k] == 0) chk($sformatf("first_addr%0d", k), addr_of(k), 0);
                idx[k]++;
                rem[k]--;
                tot--;
            end
        end
    endtask

    task automatic load_image(input int img, input bit idx_data, input int res);
        n_start = 0;
        run = 1;
        tick();
        fill(img, idx_data);
        chk("last_waddr", 32'(bus.weight_addr), N_WEIGHT - 1);
        chk("last_baddr", 32'(bus.bias_addr), N_BIAS - 1);
        chk("last_faddr", 32'(bus.fmap_addr), N_FMAP - 1);
        repeat (3) tick();
        chk("start_count", n_start, 1);
        chk("in_run", 32'(bus.state), 2);
        cdone = 1;
        cres  = 4'(res);
        tick();
        chk("done_set", 32'(bus.done_flag), 1);
        chk("result_cap", 32'(bus.result), res);
        repeat (2) tick();
        run = 0;
        tick();
        chk("done_clr", 32'(bus.done_flag), 0);
        chk("result_kept", 32'(bus.result), res);
    endtask

    task automatic soft_reset();
        srst = 1;
        tick();
        srst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_lim[0] = N_WEIGHT; m_lim[1] = N_BIAS; m_lim[2] = N_FMAP;
        model_reset();
        #12;
        compare_all();
        rstn = 1;

        // Full sequence and two back-to-back images with indexed data
        load_image(0, 0, 7);
        load_image(0, 1, 7);
        load_image(1, 1, 3);
        chk("result_replaced", 32'(bus.result), 3);

        // Overflowing weight strobe
        soft_reset();
        n_start = 0;
        run = 1;
        tick();
        for (int i = 0; i < N_WEIGHT; i++) strobe(0, $urandom());
        strobe(0, $urandom());
        chk("ovf_no_we", 32'(bus.weight_we), 0);
        chk("ovf_err", 32'(bus.err_flag), 1);
        for (int i = 0; i < N_BIAS; i++) strobe(1, $urandom());
        for (int i = 0; i < N_FMAP; i++) strobe(2, $urandom());
        repeat (3) tick();
        chk("ovf_start", n_start, 1);
        run = 0;
        tick();

        // Abort during load and during run
        soft_reset();
        n_start = 0;
        run = 1;
        tick();
        for (int i = 0; i < 100; i++) strobe(0, $urandom());
        run = 0;
        tick();
        chk("drop_idle", 32'(bus.state), 0);
        tick();
        chk("drop_no_start", n_start, 0);
        run = 1;
        tick();
        strobe(0, $urandom());
        chk("reload_addr0", 32'(bus.weight_addr), 0);
        for (int i = 1; i < N_WEIGHT; i++) strobe(0, $urandom());
        for (int i = 0; i < N_BIAS; i++) strobe(1, $urandom());
        for (int i = 0; i < N_FMAP; i++) strobe(2, $urandom());
        repeat (3) tick();
        n_abort = 0;
        run = 0;
        cdone = 1;
        cres = 4'd5;
        tick();
        repeat (2) tick();
        chk("abort_once", n_abort, 1);
        chk("abort_idle", 32'(bus.state), 0);
        cdone = 1;
        tick();
        chk("late_done", 32'(bus.done_flag), 0);

        // Simultaneous weight and fmap strobes
        soft_reset();
        run = 1;
        tick();
        strobe(2, 32'h0000_00aa);
        wd = 32'h0000_0bbb;
        w_v = 1;
        f_v = 1;
        tick();
        chk("sim_wwe", 32'(bus.weight_we), 1);
        chk("sim_fwe", 32'(bus.fmap_we), 0);
        chk("sim_err", 32'(bus.err_flag), 1);
        strobe(2, 32'h0000_0ccc);
        chk("sim_faddr", 32'(bus.fmap_addr), 1);
        run = 0;
        tick();

        // Soft reset in DONE
        soft_reset();
        load_image(2, 1, 9);
        run = 1;
        tick();
        fill(3, 0);
        repeat (3) tick();
        cdone = 1;
        cres = 4'd6;
        tick();
        chk("pre_srst_done", 32'(bus.done_flag), 1);
        soft_reset();
        chk("srst_state", 32'(bus.state), 0);
        chk("srst_result", 32'(bus.result), 0);
        chk("srst_done", 32'(bus.done_flag), 0);

        // Asynchronous reset in the middle of a load, released between edges
        for (int i = 0; i < 50; i++) strobe($urandom_range(0, 2), $urandom());
        rstn = 0;
        #2;
        model_reset();
        compare_all();
        run = 0;
        #4;
        rstn = 1;
        #1;
        chk("rel_wwe", 32'(bus.weight_we), 0);
        chk("rel_bwe", 32'(bus.bias_we), 0);
        chk("rel_fwe", 32'(bus.fmap_we), 0);
        chk("rel_state", 32'(bus.state), 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lenet_load_ctrl.md
Name: lenet_load_ctrl

Overview:
Sequencer between the AXI4-Lite slave register file and the LeNet inference core.
- Steers streamed register writes (weight 0x4, bias 0x8, fmap 0xC) into the core's weight, bias and feature-map buffers, using per-type address counters.
- Fires the core once every buffer is full and waits for its completion.
- Captures the result, and exposes the done flag (0x14) and the result (0x18).
- Handles the soft-reset register (0x1C) and the run-enable register (0x0).

Parameters:
DATA_W, 32, width of every data word
N_WEIGHT, 3220, weight words per image
N_BIAS, 10, bias words per image
N_FMAP, 784, feature-map words per image
WADDR_W, 12, weight address width (must satisfy 2^WADDR_W >= N_WEIGHT)
BADDR_W, 4, bias address width
FADDR_W, 10, fmap address width
RES_W, 4, classification result width

Ports:
s00_axi_aclk  in  1  clock; the single clock domain
s00_axi_aresetn  in  1  asynchronous, active-low reset
soft_rst  in  1  level from register 0x1C bit0; synchronous clear while high
run_en  in  1  level from register 0x0 bit0
wr_data  in  DATA_W  write data from the register file
weight_vld  in  1  one-cycle strobe: write to 0x4 accepted
bias_vld  in  1  one-cycle strobe: write to 0x8 accepted
fmap_vld  in  1  one-cycle strobe: write to 0xC accepted
mem_wdata  out  DATA_W  registered copy of wr_data
weight_we  out  1  weight buffer write enable
weight_addr  out  WADDR_W  weight buffer address
bias_we  out  1  bias buffer write enable
bias_addr  out  BADDR_W  bias buffer address
fmap_we  out  1  fmap buffer write enable
fmap_addr  out  FADDR_W  fmap buffer address
core_start  out  1  one-cycle start pulse to the core
core_abort  out  1  one-cycle abort pulse to the core
core_done  in  1  one-cycle completion pulse from the core
core_result  in  RES_W  result; valid only while core_done=1
done_flag  out  1  read through register 0x14
result  out  RES_W  read through register 0x18
err_flag  out  1  sticky error: overflow or collision
state  out  2  current FSM state, for debug

Behaviour:
Reset values (on async reset, and on any cycle with soft_rst=1)
- All outputs 0; every counter 0; state IDLE.
- soft_rst takes priority over every other event, in every state.

FSM states: IDLE=0, LOAD=1, RUN=2, DONE=3.

IDLE
- Counters held at 0; strobes ignored, with no memory write.
- run_en=1 -> LOAD on the next edge.

LOAD
- A strobe of one type on cycle t causes, on cycle t+1:
  - that type's *_we=1;
  - *_addr = that type's counter value;
  - mem_wdata = wr_data.
  - The counter then increments.
- Strobe received while that counter already equals N_*: no write, err_flag set.
- More than one strobe in the same cycle: only the highest-priority one is written (priority weight > bias > fmap); the rest are dropped and err_flag is set.
- All three counters full, and the last write issued: core_start=1 for exactly one cycle, then -> RUN.
  - core_start is asserted no earlier than the cycle after the final *_we.
- run_en=0 during LOAD: -> IDLE; counters cleared; no start pulse.

RUN
- core_done=1 -> result <= core_result, done_flag <= 1, -> DONE.
- Strobes are dropped and set err_flag.
- run_en=0 -> core_abort pulses for one cycle, -> IDLE; done_flag stays 0.
- run_en=0 and core_done=1 in the same cycle: abort wins; result is not updated.

DONE
- done_flag and result are held.
- run_en=0 -> IDLE; done_flag cleared; result retained until the next capture.
- core_done pulses are ignored.

Other rules
- core_done pulses arriving in IDLE or LOAD are ignored.
- err_flag is cleared only by reset or soft_rst.
- Counters never wrap past N_*.
- Every output is registered; there are no combinational paths from input to output.

Test Plan:
1. Full sequence: run_en=1; 3220 weight, 10 bias and 784 fmap strobes (interleaved order).
   - Required: last addresses are 3219 / 9 / 783.
   - Required: exactly one core_start.
   - Then core_done with core_result=7 -> done_flag=1, result=7.
   - Then run_en=0 -> done_flag=0, result stays 7.
2. Two back-to-back images with data values i+1000*img.
   - Required: both loads restart at address 0.
   - Required: second result (3) replaces the first (7).
3. 3221st weight strobe.
   - Required: no weight_we, err_flag=1.
   - Required: core_start still fires after bias and fmap complete.
4. run_en dropped at weight count 100.
   - Required: IDLE, no core_start.
   - Reload: weight_addr restarts at 0.
   - run_en dropped during RUN: one core_abort; a later core_done leaves done_flag=0.
5. Simultaneous weight_vld and fmap_vld.
   - Required: only weight_we; err_flag=1; fmap counter unchanged.
6. soft_rst high for 1 cycle in DONE, and s00_axi_aresetn low mid-LOAD.
   - Required in both cases: all outputs 0, state IDLE.
   - Reset deassertion at a non-edge time must leave no glitches on the *_we outputs.
